pipeline_hazard_ctrl: RTL and testbench

//  Parametrised successor hazard/forwarding controller for the 5-stage RISC-V pipeline core.

---
 rtl/risc_v_pipe_pkg.sv | 19 +
 rtl/pipeline_hazard_ctrl_mc_seq.sv | 56 +++++
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_pipe_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: forwarding selects,
// multi-cycle sequencer states and the load result-source encoding.
package risc_v_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_BUSY,
        MC_DONE
    } mc_state_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_mc_seq.sv
// Multi-cycle execute-op sequencer: holds E for MC_LAT-1 cycles, then a single
// DONE cycle in which the result is valid and the pipeline advances.
module mc_seq
    import risc_v_pipe_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic mc_start_e,
    output logic mc_hold,
    output logic mc_busy,
    output logic mc_done
);

    localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 2);

    mc_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q holds the BUSY cycles still to run, including the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MC_IDLE: begin
                if (mc_start_e) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (MC_LAT == 2) ? MC_DONE : MC_BUSY;
                end
            end
            MC_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) state_d = MC_DONE;
            end
            MC_DONE: state_d = MC_IDLE;
            default: state_d = MC_IDLE;
        endcase
    end

    assign mc_busy = (state_q == MC_BUSY);
    assign mc_done = (state_q == MC_DONE);
    assign mc_hold = ((state_q == MC_IDLE) && mc_start_e) || mc_busy;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: forwarding, load-use
// stalls, branch flushes and multi-cycle op holds. HAZ_PERF_EN adds counters.
module pipeline_hazard_ctrl
    import risc_v_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LAT     = 4
`ifdef HAZ_PERF_EN
    , parameter int CNT_W    = 32
`endif
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [1:0]            result_src_e,
    input  logic                  mc_start_e,
    input  logic                  pc_src_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_m,
    output logic [1:0]            forward_ae,
    output logic [1:0]            forward_be,
    output logic                  mc_busy,
    output logic                  mc_done
`ifdef HAZ_PERF_EN
    , output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      mc_cnt
`endif
);

    logic lw_stall;
    logic mc_hold;

    function automatic fwd_sel_e fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rdm,
        input logic                  wem,
        input logic [REG_ADDR_W-1:0] rdw,
        input logic                  wew
    );
        if (wem && (rdm != '0) && (rdm == rs)) return FWD_MEM;
        if (wew && (rdw != '0) && (rdw == rs)) return FWD_WB;
        return FWD_RF;
    endfunction

    mc_seq #(.MC_LAT(MC_LAT)) u_mc_seq (
        .clk        (clk),
        .srst       (srst),
        .mc_start_e (mc_start_e),
        .mc_hold    (mc_hold),
        .mc_busy    (mc_busy),
        .mc_done    (mc_done)
    );

    assign forward_ae = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    assign forward_be = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

    assign lw_stall = (result_src_e == RESULT_SRC_LOAD) && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    assign stall_f = lw_stall | mc_hold;
    assign stall_d = lw_stall | mc_hold;
    assign stall_e = mc_hold;
    assign flush_m = mc_hold;
    assign flush_d = pc_src_e;
    // A held E stage keeps its instruction; the load-use bubble is then redundant.
    assign flush_e = (lw_stall | pc_src_e) & ~mc_hold;

    a_no_branch_in_mc: assert property (@(posedge clk) disable iff (srst)
        !(pc_src_e && mc_hold));

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, mc_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d, flush_cnt_d, mc_cnt_d;
    logic             mc_accept;

    assign mc_accept = mc_hold & ~mc_busy;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mc_cnt_d    = mc_cnt_q;
        if (stall_f && (stall_cnt_q != '1))            stall_cnt_d = stall_cnt_q + 1'b1;
        if ((flush_d | flush_e) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
        if (mc_accept && (mc_cnt_q != '1))              mc_cnt_d    = mc_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mc_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mc_cnt_q    <= mc_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign mc_cnt    = mc_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (MC_LAT=4 and MC_LAT=2) driven
// by directed and random stimulus, checked against an occupancy-based model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       srst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] result_src_e;
    logic       mc_start_e, pc_src_e, reg_write_m, reg_write_w;

    logic [1:0] stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy, mc_done;
    logic [1:0] fwd_a [2];
    logic [1:0] fwd_b [2];
`ifdef HAZ_PERF_EN
    logic [3:0] stall_cnt [2];
    logic [3:0] flush_cnt [2];
    logic [3:0] mc_cnt    [2];
`endif

    localparam int LAT [2] = '{4, 2};

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipeline_hazard_ctrl #(
            .REG_ADDR_W (5),
            .MC_LAT     ((g == 0) ? 4 : 2)
`ifdef HAZ_PERF_EN
            , .CNT_W    (4)
`endif
        ) u_dut (
            .clk          (clk),
            .srst         (srst),
            .rs1_d        (rs1_d),
            .rs2_d        (rs2_d),
            .rs1_e        (rs1_e),
            .rs2_e        (rs2_e),
            .rd_e         (rd_e),
            .result_src_e (result_src_e),
            .mc_start_e   (mc_start_e),
            .pc_src_e     (pc_src_e),
            .rd_m         (rd_m),
            .reg_write_m  (reg_write_m),
            .rd_w         (rd_w),
            .reg_write_w  (reg_write_w),
            .stall_f      (stall_f[g]),
            .stall_d      (stall_d[g]),
            .stall_e      (stall_e[g]),
            .flush_d      (flush_d[g]),
            .flush_e      (flush_e[g]),
            .flush_m      (flush_m[g]),
            .forward_ae   (fwd_a[g]),
            .forward_be   (fwd_b[g]),
            .mc_busy      (mc_busy[g]),
            .mc_done      (mc_done[g])
`ifdef HAZ_PERF_EN
            , .stall_cnt  (stall_cnt[g]),
            .flush_cnt    (flush_cnt[g]),
            .mc_cnt       (mc_cnt[g])
`endif
        );
    end

    int checks   = 0;
    int failures = 0;

    // Model: age = index of the current cycle within an in-flight op (0 = none).
    int age [2] = '{0, 0};
    int m_stall [2] = '{0, 0};
    int m_flush [2] = '{0, 0};
    int m_mc    [2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int op_idx(input int i);
        if (age[i] != 0) return age[i];
        return mc_start_e ? 1 : 0;
    endfunction

    function automatic bit m_hold(input int i);
        int k = op_idx(i);
        return (k != 0) && (k < LAT[i]);
    endfunction

    function automatic bit m_lw();
        return (result_src_e == 2'b01) && (rd_e != 0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_cycle();
        for (int i = 0; i < 2; i++) begin
            int k     = op_idx(i);
            bit hold  = m_hold(i);
            bit lw    = m_lw();
            chk($sformatf("stall_f%0d", i), stall_f[i], lw | hold);
            chk($sformatf("stall_d%0d", i), stall_d[i], lw | hold);
            chk($sformatf("stall_e%0d", i), stall_e[i], hold);
            chk($sformatf("flush_m%0d", i), flush_m[i], hold);
            chk($sformatf("flush_d%0d", i), flush_d[i], pc_src_e);
            chk($sformatf("flush_e%0d", i), flush_e[i], (lw | pc_src_e) & ~hold);
            chk($sformatf("mc_busy%0d", i), mc_busy[i], (k >= 2) && (k < LAT[i]));
            chk($sformatf("mc_done%0d", i), mc_done[i], k == LAT[i]);
            chk($sformatf("fwd_a%0d", i), fwd_a[i], ref_fwd(rs1_e));
            chk($sformatf("fwd_b%0d", i), fwd_b[i], ref_fwd(rs2_e));
`ifdef HAZ_PERF_EN
            chk($sformatf("stall_cnt%0d", i), stall_cnt[i], m_stall[i]);
            chk($sformatf("flush_cnt%0d", i), flush_cnt[i], m_flush[i]);
            chk($sformatf("mc_cnt%0d", i), mc_cnt[i], m_mc[i]);
`endif
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            int k    = op_idx(i);
            bit hold = m_hold(i);
            bit lw   = m_lw();
            if (srst) begin
                age[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_mc[i] = 0;
            end else begin
                if ((lw | hold) && m_stall[i] < 15) m_stall[i]++;
                if ((pc_src_e | ((lw | pc_src_e) & ~hold)) && m_flush[i] < 15) m_flush[i]++;
                if (age[i] == 0 && mc_start_e && m_mc[i] < 15) m_mc[i]++;
                age[i] = (k == 0 || k == LAT[i]) ? 0 : k + 1;
            end
        end
        #1;
    endtask

    task automatic step();
        #4;
        check_cycle();
        advance();
    endtask

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        result_src_e = 0; mc_start_e = 0; pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
    endtask

    task automatic rand_inputs();
        rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
        rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
        rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
        rd_w  = 5'($urandom_range(0, 3));
        result_src_e = 2'($urandom_range(0, 3));
        reg_write_m  = 1'($urandom_range(0, 1));
        reg_write_w  = 1'($urandom_range(0, 1));
        mc_start_e   = ($urandom_range(0, 5) == 0);
        srst         = ($urandom_range(0, 49) == 0);
        pc_src_e     = ($urandom_range(0, 4) == 0) && !m_hold(0) && !m_hold(1);
    endtask

    initial begin
        clear_inputs();
        srst = 1'b1;
        advance();
        advance();
        srst = 1'b0;

        // Reset state with idle inputs.
        #4;
        chk("rst_busy", mc_busy, 2'b00);
        chk("rst_done", mc_done, 2'b00);
        chk("rst_stall", stall_f, 2'b00);
        check_cycle();
        advance();

        // Forwarding priority: MEM beats WB, rd_m==0 falls back to WB.
        reg_write_m = 1; rd_m = 5; rs1_e = 5; reg_write_w = 1; rd_w = 5;
        #4;
        chk("t1_mem", fwd_a[0], 2'b10);
        check_cycle();
        rd_m = 0;
        #1;
        chk("t1_wb", fwd_a[0], 2'b01);
        check_cycle();
        advance();
        clear_inputs();

        // Load-use stall, then rd_e==0 suppresses it.
        result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        #4;
        chk("t2_stall", {stall_f[0], stall_d[0], flush_e[0]}, 3'b111);
        check_cycle();
        advance();
        rd_e = 0;
        #4;
        chk("t2_nostall", {stall_f[0], flush_e[0]}, 2'b00);
        check_cycle();
        advance();
        clear_inputs();

        // mc_start held 4 cycles: MC_LAT=4 runs one op, MC_LAT=2 runs two.
        mc_start_e = 1;
        for (int c = 1; c <= 4; c++) begin
            #4;
            chk($sformatf("t3_hold_c%0d", c), {stall_e[0], flush_m[0]}, (c <= 3) ? 2'b11 : 2'b00);
            chk($sformatf("t3_busy_c%0d", c), mc_busy[0], (c == 2 || c == 3));
            chk($sformatf("t3_done_c%0d", c), mc_done[0], c == 4);
            chk($sformatf("t4_stall_c%0d", c), stall_f[1], c[0]);
            chk($sformatf("t4_done_c%0d", c), mc_done[1], !c[0]);
            check_cycle();
            advance();
        end
        clear_inputs();

        // Branch together with a load-use hazard.
        pc_src_e = 1; result_src_e = 2'b01; rd_e = 3; rs1_d = 3;
        #4;
        chk("t5_flush", {flush_d, flush_e, stall_f}, 6'b111111);
        check_cycle();
        advance();
        clear_inputs();

        // Reset while the MC_LAT=4 sequencer is busy.
        mc_start_e = 1;
        step();
        mc_start_e = 0;
        #4;
        chk("t5_busy_pre", mc_busy[0], 1'b1);
        check_cycle();
        srst = 1;
        advance();
        srst = 0;
        #4;
        chk("t5_busy_post", mc_busy[0], 1'b0);
        chk("t5_stall_post", {stall_f[0], stall_e[0]}, 2'b00);
        check_cycle();
        advance();

`ifdef HAZ_PERF_EN
        // 20 load-use stall cycles saturate a 4-bit counter.
        result_src_e = 2'b01; rd_e = 9; rs1_d = 9;
        repeat (20) step();
        clear_inputs();
        #4;
        chk("t6_sat", stall_cnt[0], 4'hF);
        check_cycle();
        advance();
        srst = 1;
        advance();
        srst = 0;
        #4;
        chk("t6_clr", stall_cnt[0], 4'h0);
        check_cycle();
        advance();
`endif

        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            step();
        end
        srst = 0;
        clear_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
